// File: rtl/spi_slave_if.sv
// Bundle of write-FIFO, read-FIFO and SPI pin signals seen by spi_slave.
interface spi_slave_if #(
  parameter int W = 8
);
  logic [W:0]   out;
  logic         put;
  logic         full;
  logic [W-1:0] in;
  logic         get;
  logic         empty;
  logic         spi_cs_n;
  logic         spi_clock;
  logic         spi_dc;
  logic         spi_mosi;
  logic         spi_miso;
  logic         spi_miso_oe;

  modport slave (
    output out, put, get, spi_miso, spi_miso_oe,
    input  full, in, empty, spi_cs_n, spi_clock, spi_dc, spi_mosi
  );

  modport master (
    input  out, put, get, spi_miso, spi_miso_oe,
    output full, in, empty, spi_cs_n, spi_clock, spi_dc, spi_mosi
  );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI target with D/C bit, oversampled by the system clock; frames go to a write FIFO.
// Define SPI_SLAVE_STATUS_EN to add sticky overrun/underrun status outputs.
//
// state  | meaning
// IDLE   | cs_n high, SCK edges ignored
// ACTIVE | cs_n low, shifting frames
module spi_slave #(
  parameter int         W    = 8,
  parameter logic [7:0] FILL = 8'hFF
) (
  input  logic        clock,
  input  logic        reset_n,
  spi_slave_if.slave  bus
`ifdef SPI_SLAVE_STATUS_EN
  ,
  output logic        overrun,
  output logic        underrun
`endif
);

  localparam int         CW     = $clog2(W + 1);
  localparam logic [W-1:0] FILL_W = W'(FILL);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic cs_s1, cs_s2, cs_h;
  logic sck_s1, sck_s2, sck_h;
  logic dc_s1, dc_s2;
  logic mosi_s1, mosi_s2;

  logic [CW-1:0] cnt;
  logic [W-1:0]  rx_sh, rx_next;
  logic [W-1:0]  tx_sh, tx_buf, tx_load;
  logic          tx_valid, get_d, reload_pend;
  logic          cs_fall, cs_rise, rise_ok, fall_ok, last_bit, reload;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_h    <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_h   <= 1'b0;
      dc_s1   <= 1'b0;
      dc_s2   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= bus.spi_cs_n;
      cs_s2   <= cs_s1;
      cs_h    <= cs_s2;
      sck_s1  <= bus.spi_clock;
      sck_s2  <= sck_s1;
      sck_h   <= sck_s2;
      dc_s1   <= bus.spi_dc;
      dc_s2   <= dc_s1;
      mosi_s1 <= bus.spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign cs_fall  = cs_h & ~cs_s2;
  assign cs_rise  = ~cs_h & cs_s2;
  assign rise_ok  = (state_q == ACTIVE) & ~cs_rise & ~sck_h & sck_s2;
  assign fall_ok  = (state_q == ACTIVE) & ~cs_rise & sck_h & ~sck_s2;
  assign last_bit = rise_ok & (cnt == CW'(W - 1));
  // The next frame's first bit is presented on the SCK fall that follows the last bit.
  assign reload   = cs_fall | (fall_ok & reload_pend);
  assign tx_load  = tx_valid ? tx_buf : FILL_W;
  assign rx_next  = {rx_sh[W-2:0], mosi_s2};
  assign bus.spi_miso_oe = ~cs_s2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      rx_sh        <= '0;
      reload_pend  <= 1'b0;
      bus.out      <= '0;
      bus.put      <= 1'b0;
      tx_sh        <= '0;
      tx_buf       <= '0;
      tx_valid     <= 1'b0;
      get_d        <= 1'b0;
      bus.get      <= 1'b0;
      bus.spi_miso <= 1'b1;
`ifdef SPI_SLAVE_STATUS_EN
      overrun      <= 1'b0;
      underrun     <= 1'b0;
`endif
    end else begin
      bus.put <= 1'b0;
      if (cs_rise || cs_fall) begin
        cnt         <= '0;
        reload_pend <= 1'b0;
      end else if (rise_ok) begin
        rx_sh <= rx_next;
        if (last_bit) begin
          cnt         <= '0;
          reload_pend <= 1'b1;
          if (!bus.full) begin
            bus.put <= 1'b1;
            bus.out <= {dc_s2, rx_next};
          end
`ifdef SPI_SLAVE_STATUS_EN
          else overrun <= 1'b1;
`endif
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (fall_ok && reload_pend) begin
        reload_pend <= 1'b0;
      end

      if (reload) begin
        tx_sh        <= tx_load;
        bus.spi_miso <= tx_load[W-1];
`ifdef SPI_SLAVE_STATUS_EN
        if (!tx_valid) underrun <= 1'b1;
`endif
      end else if (fall_ok) begin
        tx_sh        <= {tx_sh[W-2:0], 1'b0};
        bus.spi_miso <= tx_sh[W-2];
      end

      // get_d guards the capture cycle so one slot never sees two reads.
      get_d   <= bus.get;
      bus.get <= ~tx_valid & ~bus.empty & ~bus.get & ~get_d;
      if (get_d) begin
        tx_buf   <= bus.in;
        tx_valid <= 1'b1;
      end else if (reload) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: acts as SPI master plus write/read FIFO models.
module tb_spi_slave;
  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   put_cnt;
  int   get_cnt;
  logic [8:0] rx_q[$];
  logic [7:0] rdq[$];

  spi_slave_if #(.W(8)) bus ();

`ifdef SPI_SLAVE_STATUS_EN
  logic overrun, underrun;
  spi_slave #(.W(8), .FILL(8'hFF)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus), .overrun(overrun), .underrun(underrun)
  );
`else
  spi_slave #(.W(8), .FILL(8'hFF)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // FIFO models: sample strobes mid-cycle, present read data for the following capture edge.
  always @(negedge clock) begin
    if (bus.put) begin
      put_cnt++;
      rx_q.push_back(bus.out);
    end
    if (bus.get) begin
      get_cnt++;
      if (rdq.size() > 0) bus.in = rdq.pop_front();
    end
    bus.empty = (rdq.size() == 0);
  end

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #50;
    bus.spi_cs_n = 1'b1;
    #100;
  endtask

  task automatic xfer(input logic [8:0] word, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    bus.spi_dc = word[8];
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi = word[i];
      #50;
      bus.spi_clock = 1'b1;
      mi[i] = bus.spi_miso;
      #50;
      bus.spi_clock = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.out !== 9'h000) begin errors++; $display("FAIL reset_out got %h exp 000", bus.out); end
    checks++; if (bus.put !== 1'b0) begin errors++; $display("FAIL reset_put got %b exp 0", bus.put); end
    checks++; if (bus.get !== 1'b0) begin errors++; $display("FAIL reset_get got %b exp 0", bus.get); end
    checks++; if (bus.spi_miso !== 1'b1) begin errors++; $display("FAIL reset_miso got %b exp 1", bus.spi_miso); end
    checks++; if (bus.spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", bus.spi_miso_oe); end
    #200;
    checks++; if (get_cnt !== 0) begin errors++; $display("FAIL idle_no_get got %0d exp 0", get_cnt); end
`ifdef SPI_SLAVE_STATUS_EN
    checks++; if ({overrun, underrun} !== 2'b00) begin errors++; $display("FAIL reset_status got %b exp 00", {overrun, underrun}); end
`endif
  endtask

  task automatic test_write();
    logic [7:0] mi;
    int p0;
    p0 = put_cnt;
    rx_q.delete();
    cs_low();
    checks++; if (bus.spi_miso_oe !== 1'b1) begin errors++; $display("FAIL active_oe got %b exp 1", bus.spi_miso_oe); end
    xfer(9'h048, 8, mi);
    checks++; if (mi !== 8'hFF) begin errors++; $display("FAIL write_fill got %h exp FF", mi); end
    xfer(9'h165, 8, mi);
    cs_high();
    checks++; if (bus.spi_miso_oe !== 1'b0) begin errors++; $display("FAIL idle_oe got %b exp 0", bus.spi_miso_oe); end
    checks++; if (put_cnt - p0 !== 2) begin errors++; $display("FAIL write_puts got %0d exp 2", put_cnt - p0); end
    checks++; if (rx_q.size() < 1 || rx_q[0] !== 9'h048) begin errors++; $display("FAIL write_word0 got %h exp 048", rx_q.size() > 0 ? rx_q[0] : 9'h1ff); end
    checks++; if (rx_q.size() < 2 || rx_q[1] !== 9'h165) begin errors++; $display("FAIL write_word1 got %h exp 165", rx_q.size() > 1 ? rx_q[1] : 9'h1ff); end
    #200;
    checks++; if (bus.out !== 9'h165) begin errors++; $display("FAIL out_hold got %h exp 165", bus.out); end
  endtask

  task automatic test_read();
    logic [7:0] mi0, mi1;
    int g0;
    g0 = get_cnt;
    rdq.push_back(8'hA5);
    rdq.push_back(8'h3C);
    #100;
    cs_low();
    xfer(9'h011, 8, mi0);
    xfer(9'h022, 8, mi1);
    cs_high();
    checks++; if (mi0 !== 8'hA5) begin errors++; $display("FAIL read_byte0 got %h exp A5", mi0); end
    checks++; if (mi1 !== 8'h3C) begin errors++; $display("FAIL read_byte1 got %h exp 3C", mi1); end
    checks++; if (get_cnt - g0 !== 2) begin errors++; $display("FAIL read_gets got %0d exp 2", get_cnt - g0); end
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    int g0;
    g0 = get_cnt;
    cs_low();
    for (int k = 0; k < 3; k++) begin
      xfer(9'h0F0 + 9'(k), 8, mi);
      checks++; if (mi !== 8'hFF) begin errors++; $display("FAIL underrun_byte%0d got %h exp FF", k, mi); end
    end
    cs_high();
    checks++; if (get_cnt - g0 !== 0) begin errors++; $display("FAIL underrun_gets got %0d exp 0", get_cnt - g0); end
`ifdef SPI_SLAVE_STATUS_EN
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag got %b exp 1", underrun); end
`endif
  endtask

  task automatic test_overrun();
    logic [7:0] mi;
    int p0;
    p0 = put_cnt;
    rx_q.delete();
    bus.full = 1'b1;
    cs_low();
    xfer(9'h16C, 8, mi);
    bus.full = 1'b0;
    xfer(9'h06C, 8, mi);
    cs_high();
    checks++; if (put_cnt - p0 !== 1) begin errors++; $display("FAIL overrun_puts got %0d exp 1", put_cnt - p0); end
    checks++; if (rx_q.size() < 1 || rx_q[0] !== 9'h06C) begin errors++; $display("FAIL overrun_word got %h exp 06C", rx_q.size() > 0 ? rx_q[0] : 9'h1ff); end
`ifdef SPI_SLAVE_STATUS_EN
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b exp 1", overrun); end
`endif
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int p0;
    p0 = put_cnt;
    rx_q.delete();
    cs_low();
    xfer(9'h1FF, 5, mi);
    cs_high();
    cs_low();
    xfer(9'h00D, 8, mi);
    cs_high();
    checks++; if (put_cnt - p0 !== 1) begin errors++; $display("FAIL abort_puts got %0d exp 1", put_cnt - p0); end
    checks++; if (rx_q.size() < 1 || rx_q[0] !== 9'h00D) begin errors++; $display("FAIL abort_word got %h exp 00D", rx_q.size() > 0 ? rx_q[0] : 9'h1ff); end
    // Reset pulsed with SCK high in the middle of a byte.
    cs_low();
    bus.spi_mosi = 1'b1;
    #50;
    bus.spi_clock = 1'b1;
    #20;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.out !== 9'h000) begin errors++; $display("FAIL midreset_out got %h exp 000", bus.out); end
    checks++; if (bus.spi_miso_oe !== 1'b0) begin errors++; $display("FAIL midreset_oe got %b exp 0", bus.spi_miso_oe); end
    checks++; if ({bus.put, bus.get, bus.spi_miso} !== 3'b001) begin errors++; $display("FAIL midreset_strobes got %b exp 001", {bus.put, bus.get, bus.spi_miso}); end
    #9;
    bus.spi_clock = 1'b0;
    bus.spi_cs_n = 1'b1;
    #30;
    reset_n = 1'b1;
    #100;
    checks++; if (bus.out !== 9'h000) begin errors++; $display("FAIL postreset_out got %h exp 000", bus.out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    put_cnt = 0;
    get_cnt = 0;
    reset_n = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_clock = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_dc = 1'b0;
    bus.full = 1'b0;
    bus.empty = 1'b1;
    bus.in = 8'h00;
    #20;
    reset_n = 1'b1;
    #20;
    test_reset();
    test_write();
    test_read();
    test_underrun();
    test_overrun();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
